// File: rtl/ddr_global_pkg.sv
// Shared wddr datapath definitions: FIFO ratio limit and FIFO operating mode.
package ddr_global_pkg;

   localparam int DDR_FIFO_WC_MAX_RATIO = 8;

   typedef enum logic {
      FIFO_NORMAL,
      FIFO_LOOP
   } ddr_fifo_mode_t;

endpackage

// File: rtl/ddr_fifo_wc_mem.sv
// DEPTH x (RATIO*RWIDTH) flop register file: one write port, slice-muxed async read.
// Storage has no reset; clearing the FIFO only moves pointers.
module ddr_fifo_wc_mem
   import ddr_global_pkg::*;
#(
   parameter int RWIDTH = 32,
   parameter int RATIO  = 2,
   parameter int DEPTH  = 8,
   parameter int AWIDTH = $clog2(DEPTH),
   parameter int SWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
)(
   input  logic                    clk,
   input  logic                    wen,
   input  logic [AWIDTH-1:0]       waddr,
   input  logic [RWIDTH*RATIO-1:0] wdata,
   input  logic [AWIDTH-1:0]       raddr,
   input  logic [SWIDTH-1:0]       sidx,
   output logic [RWIDTH-1:0]       rdata
);

   // each entry viewed as RATIO slices; slice 0 is the low RWIDTH bits
   logic [RATIO-1:0][RWIDTH-1:0] mem [DEPTH];

   // capture an accepted write word
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   // present the slice selected by the read pointer and slice index
   always_comb begin
      rdata = mem[raddr][sidx];
   end

endmodule

// File: rtl/ddr_fifo_wc.sv
// Single-clock FIFO with write-to-read width down-conversion (RATIO slices per word),
// occupancy level, almost-full/almost-empty compares and loop (replay) mode.
// Optional feature macro: DDR_FIFO_WC_ERR_EN enables sticky o_ovf/o_udf flags;
// when undefined both flags are tied low and no flag flops exist.
module ddr_fifo_wc
   import ddr_global_pkg::*;
#(
   parameter int RWIDTH = 32,
   parameter int RATIO  = 2,
   parameter int DEPTH  = 8,
   parameter int WWIDTH = RWIDTH * RATIO,
   parameter int AWIDTH = $clog2(DEPTH),
   parameter int SWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
)(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_loop_mode,
   input  logic              i_load_ptr,
   input  logic [AWIDTH-1:0] i_start_ptr,
   input  logic [AWIDTH-1:0] i_stop_ptr,
   input  logic [AWIDTH:0]   i_afull_thr,
   input  logic [AWIDTH:0]   i_aempty_thr,
   input  logic              i_write,
   input  logic [WWIDTH-1:0] i_wdata,
   output logic              o_full,
   output logic              o_afull,
   input  logic              i_read,
   output logic [RWIDTH-1:0] o_rdata,
   output logic              o_empty_n,
   output logic              o_aempty,
   output logic [AWIDTH:0]   o_level,
   output logic              o_ovf,
   output logic              o_udf
);

   localparam logic [AWIDTH-1:0] PTR_ONE   = AWIDTH'(1);
   localparam logic [SWIDTH-1:0] SIDX_ONE  = SWIDTH'(1);
   localparam logic [SWIDTH-1:0] SIDX_LAST = SWIDTH'(RATIO - 1);
   localparam logic [AWIDTH:0]   LVL_ONE   = (AWIDTH + 1)'(1);
   localparam logic [AWIDTH:0]   LVL_DEPTH = (AWIDTH + 1)'(DEPTH);

   logic [AWIDTH-1:0] wptr, wptr_n;
   logic [AWIDTH-1:0] rptr, rptr_n;
   logic [SWIDTH-1:0] sidx, sidx_n;
   logic [AWIDTH:0]   level, level_n;
   logic              full, empty_n;
   logic              wr_ok, rd_ok, rd_done, rd_free;
   logic              mem_wen;
   ddr_fifo_mode_t    mode;

   assign mode    = i_loop_mode ? FIFO_LOOP : FIFO_NORMAL;
   assign full    = (level == LVL_DEPTH);
   assign empty_n = (level != '0);

   // acceptance uses registered full/empty only, so a same-cycle read never admits a write
   assign wr_ok   = i_write & ~full;
   assign rd_ok   = i_read & empty_n;
   assign rd_done = rd_ok & (sidx == SIDX_LAST);
   assign rd_free = rd_done & (mode == FIFO_NORMAL);
   assign mem_wen = wr_ok & ~i_clr & ~i_load_ptr;

   // next pointer/slice/level state with clear > load > write/read priority
   always_comb begin
      wptr_n  = wptr;
      rptr_n  = rptr;
      sidx_n  = sidx;
      level_n = level;
      if (i_clr) begin
         wptr_n  = '0;
         rptr_n  = '0;
         sidx_n  = '0;
         level_n = '0;
      end else if (i_load_ptr) begin
         wptr_n  = i_start_ptr;
         rptr_n  = i_start_ptr;
         sidx_n  = '0;
         level_n = '0;
      end else begin
         if (wr_ok) begin
            wptr_n = wptr + PTR_ONE;
         end
         if (rd_done) begin
            sidx_n = '0;
            if (mode == FIFO_LOOP) begin
               rptr_n = (rptr == i_stop_ptr) ? i_start_ptr : rptr + PTR_ONE;
            end else begin
               rptr_n = rptr + PTR_ONE;
            end
         end else if (rd_ok) begin
            sidx_n = sidx + SIDX_ONE;
         end
         // in loop mode a completed entry stays occupied for replay
         case ({wr_ok, rd_free})
            2'b10:   level_n = level + LVL_ONE;
            2'b01:   level_n = level - LVL_ONE;
            default: level_n = level;
         endcase
      end
   end

   // pointer, slice index and level registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         sidx  <= '0;
         level <= '0;
      end else begin
         wptr  <= wptr_n;
         rptr  <= rptr_n;
         sidx  <= sidx_n;
         level <= level_n;
      end
   end

`ifdef DDR_FIFO_WC_ERR_EN
   logic ovf, udf;

   // sticky overflow/underflow flags, cleared only by reset or clear
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (i_clr) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else if (!i_load_ptr) begin
         if (i_write && full) begin
            ovf <= 1'b1;
         end
         if (i_read && !empty_n) begin
            udf <= 1'b1;
         end
      end
   end

   assign o_ovf = ovf;
   assign o_udf = udf;
`else
   assign o_ovf = 1'b0;
   assign o_udf = 1'b0;
`endif

   assign o_full    = full;
   assign o_empty_n = empty_n;
   assign o_level   = level;
   assign o_afull   = (level >= i_afull_thr);
   assign o_aempty  = (level <= i_aempty_thr);

   ddr_fifo_wc_mem #(
      .RWIDTH (RWIDTH),
      .RATIO  (RATIO),
      .DEPTH  (DEPTH),
      .AWIDTH (AWIDTH),
      .SWIDTH (SWIDTH)
   ) u_mem (
      .clk   (i_clk),
      .wen   (mem_wen),
      .waddr (wptr),
      .wdata (i_wdata),
      .raddr (rptr),
      .sidx  (sidx),
      .rdata (o_rdata)
   );

endmodule

// File: tb/tb_ddr_fifo_wc.sv
// Directed self-checking bench for ddr_fifo_wc at default parameters
// (RWIDTH=32, RATIO=2, DEPTH=8). Expected flag values follow DDR_FIFO_WC_ERR_EN.
module tb_ddr_fifo_wc;

`ifdef DDR_FIFO_WC_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        loop_mode;
   logic        load_ptr;
   logic [2:0]  start_ptr;
   logic [2:0]  stop_ptr;
   logic [3:0]  afull_thr;
   logic [3:0]  aempty_thr;
   logic        write;
   logic [63:0] wdata;
   logic        full;
   logic        afull;
   logic        read;
   logic [31:0] rdata;
   logic        empty_n;
   logic        aempty;
   logic [3:0]  level;
   logic        ovf;
   logic        udf;

   int checks = 0;
   int errors = 0;

   ddr_fifo_wc #(
      .RWIDTH (32),
      .RATIO  (2),
      .DEPTH  (8)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_clr        (clr),
      .i_loop_mode  (loop_mode),
      .i_load_ptr   (load_ptr),
      .i_start_ptr  (start_ptr),
      .i_stop_ptr   (stop_ptr),
      .i_afull_thr  (afull_thr),
      .i_aempty_thr (aempty_thr),
      .i_write      (write),
      .i_wdata      (wdata),
      .o_full       (full),
      .o_afull      (afull),
      .i_read       (read),
      .o_rdata      (rdata),
      .o_empty_n    (empty_n),
      .o_aempty     (aempty),
      .o_level      (level),
      .o_ovf        (ovf),
      .o_udf        (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d);
      write = 1'b1;
      wdata = d;
      tick();
      write = 1'b0;
   endtask

   task automatic pop();
      read = 1'b1;
      tick();
      read = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; loop_mode = 1'b0; load_ptr = 1'b0;
      start_ptr = '0; stop_ptr = '0; afull_thr = 4'd0; aempty_thr = 4'd1;
      write = 1'b0; wdata = '0; read = 1'b0;
      repeat (2) tick();
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got=%b exp=0", empty_n); end
      checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", aempty); end
      checks++; if (afull !== 1'b1) begin errors++; $display("FAIL reset_afull_thr0 got=%b exp=1", afull); end
      checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {ovf, udf}); end
      afull_thr = 4'd6;
      #1;
      checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull_thr6 got=%b exp=0", afull); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         push(64'h1111_0000_0000_0000 + 64'(i));
         checks++; if (level !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
         checks++; if (afull !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, afull, (i + 1 >= 6)); end
         checks++; if (aempty !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", i, aempty, (i + 1 <= 1)); end
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
      checks++; if (empty_n !== 1'b1) begin errors++; $display("FAIL fill_empty_n got=%b exp=1", empty_n); end
   endtask

   task automatic test_drain();
      logic [31:0] exp_d;
      for (int k = 0; k < 16; k++) begin
         exp_d = (k % 2 == 0) ? 32'(k / 2) : 32'h1111_0000;
         checks++; if (rdata !== exp_d) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", k, rdata, exp_d); end
         pop();
         checks++; if (level !== 4'(8 - (k + 1) / 2)) begin errors++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", k, level, 8 - (k + 1) / 2); end
      end
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL drain_empty_n got=%b exp=0", empty_n); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got=%b exp=0", full); end
   endtask

   task automatic test_ovf_udf();
      pop();
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL udf_level got=%0d exp=0", level); end
      checks++; if (udf !== ERR) begin errors++; $display("FAIL udf_flag got=%b exp=%b", udf, ERR); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL udf_no_ovf got=%b exp=0", ovf); end
      for (int i = 0; i < 8; i++) push({32'hA000_0000 + 32'(i), 32'hA100_0000 + 32'(i)});
      push(64'hDEAD_BEEF_DEAD_BEEF);
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d exp=8", level); end
      checks++; if (ovf !== ERR) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", ovf, ERR); end
      checks++; if (rdata !== 32'hA100_0000) begin errors++; $display("FAIL ovf_data got=%h exp=a1000000", rdata); end
      pop();
      checks++; if (rdata !== 32'hA000_0000) begin errors++; $display("FAIL ovf_data_hi got=%h exp=a0000000", rdata); end
      checks++; if (udf !== ERR) begin errors++; $display("FAIL udf_sticky got=%b exp=%b", udf, ERR); end
      do_clr();
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL clr_level got=%0d exp=0", level); end
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL clr_empty_n got=%b exp=0", empty_n); end
      checks++; if ({ovf, udf} !== 2'b00) begin errors++; $display("FAIL clr_flags got=%b exp=00", {ovf, udf}); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) push({32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)});
      pop();
      checks++; if (level !== 4'd4) begin errors++; $display("FAIL sim_pre_level got=%0d exp=4", level); end
      write = 1'b1; wdata = {32'hB000_0004, 32'hC000_0004}; read = 1'b1;
      tick();
      write = 1'b0; read = 1'b0;
      checks++; if (level !== 4'd4) begin errors++; $display("FAIL sim_wr_rd_level got=%0d exp=4", level); end
      checks++; if (rdata !== 32'hC000_0001) begin errors++; $display("FAIL sim_wr_rd_data got=%h exp=c0000001", rdata); end
      for (int i = 5; i < 9; i++) push({32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)});
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_full got=%b exp=1", full); end
      write = 1'b1; wdata = 64'h9999_9999_9999_9999; read = 1'b1;
      tick();
      write = 1'b0; read = 1'b0;
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL sim_full_rd_level got=%0d exp=8", level); end
      checks++; if (ovf !== ERR) begin errors++; $display("FAIL sim_full_ovf got=%b exp=%b", ovf, ERR); end
      checks++; if (rdata !== 32'hB000_0001) begin errors++; $display("FAIL sim_full_rejected_data got=%h exp=b0000001", rdata); end
      pop();
      checks++; if (level !== 4'd7) begin errors++; $display("FAIL sim_after_level got=%0d exp=7", level); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL sim_after_full got=%b exp=0", full); end
      do_clr();
   endtask

   task automatic test_loop();
      logic [31:0] exp_d;
      int          ent;
      load_ptr = 1'b1; start_ptr = 3'd2; stop_ptr = 3'd5; loop_mode = 1'b1;
      tick();
      load_ptr = 1'b0;
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL loop_load_level got=%0d exp=0", level); end
      for (int e = 2; e < 6; e++) push({32'hE000_0000 + 32'(e), 32'hF000_0000 + 32'(e)});
      checks++; if (level !== 4'd4) begin errors++; $display("FAIL loop_fill_level got=%0d exp=4", level); end
      for (int k = 0; k < 12; k++) begin
         ent = 2 + (k / 2) % 4;
         exp_d = (k % 2 == 0) ? 32'hF000_0000 + 32'(ent) : 32'hE000_0000 + 32'(ent);
         checks++; if (rdata !== exp_d) begin errors++; $display("FAIL loop_data[%0d] got=%h exp=%h", k, rdata, exp_d); end
         pop();
         checks++; if (level !== 4'd4) begin errors++; $display("FAIL loop_level[%0d] got=%0d exp=4", k, level); end
      end
      load_ptr = 1'b1; start_ptr = 3'd0; loop_mode = 1'b0;
      tick();
      load_ptr = 1'b0;
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL loop_exit_empty_n got=%b exp=0", empty_n); end
   endtask

   task automatic test_reset_midop();
      do_clr();
      for (int i = 0; i < 5; i++) push({32'h5A00_0000 + 32'(i), 32'h5500_0000 + 32'(i)});
      pop();
      checks++; if (rdata !== 32'h5A00_0000) begin errors++; $display("FAIL midop_pre_data got=%h exp=5a000000", rdata); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL midop_level got=%0d exp=0", level); end
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL midop_empty_n got=%b exp=0", empty_n); end
      checks++; if (aempty !== 1'b1) begin errors++; $display("FAIL midop_aempty got=%b exp=1", aempty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL midop_full got=%b exp=0", full); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push({32'h7777_0000, 32'h6666_0000});
      checks++; if (rdata !== 32'h6666_0000) begin errors++; $display("FAIL midop_entry0_lo got=%h exp=66660000", rdata); end
      checks++; if (level !== 4'd1) begin errors++; $display("FAIL midop_post_level got=%0d exp=1", level); end
      pop();
      checks++; if (rdata !== 32'h7777_0000) begin errors++; $display("FAIL midop_entry0_hi got=%h exp=77770000", rdata); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_ovf_udf();
      test_simultaneous();
      test_loop();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
